acs_multi_branch: RTL
=====================

Name: acs_multi_branch

Overview:
Parametrised add-compare-select unit for the multi-h CPM trellis decoder. It is the successor to the fixed 4-way ACS and generalises the branch count, metric width and input width. It collects a serial stream of rotated branch metrics (one per valid clock), adds each to its predecessor accumulated metric with saturation, and selects the maximum through a pipelined compare tree. It outputs the survivor index, the survivor metric and the winning rotated I/Q, and handles normalisation request and apply.

Parameters:
NUM_BR, 4, branches per state; power of 2, 2..8
ACS_BITS, 12, accumulated metric width (signed two's complement)
ROT_BITS, 8, rotated I/Q width (signed)
SEL_W, $clog2(NUM_BR), survivor index width (derived, local)
NORM_VAL, 2**(ACS_BITS-2), amount subtracted when normalising

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
bm_valid  in  1  bm_i/bm_q valid this clock
bm_first  in  1  marks branch 0 of a symbol; qualified by bm_valid
bm_i  in  ROT_BITS  rotated I (the metric contribution)
bm_q  in  ROT_BITS  rotated Q (carried to output only)
acc_met_in  in  NUM_BR*ACS_BITS  predecessor metrics, branch k at [k*ACS_BITS +: ACS_BITS]; sampled on the launch cycle
norm_in  in  1  global normalise command for this symbol
out_valid  out  1  one-cycle strobe: outputs updated
sel_out  out  SEL_W  winning branch index
acc_met_out  out  ACS_BITS  survivor metric
i_out  out  ROT_BITS  winning rotated I
q_out  out  ROT_BITS  winning rotated Q
norm_req  out  1  survivor metric approaching overflow
frag_err  out  1  one-cycle pulse: incomplete symbol discarded

Behaviour:
- Reset: all outputs 0, branch counter 0, FSM=COLLECT, all pipeline valids cleared. Reset mid-operation discards in-flight data; no out_valid is issued for it.
- FSM:
  - COLLECT: each bm_valid writes branch register [cnt] and increments cnt. bm_valid&bm_first forces the write to index 0 and sets cnt=1.
  - When index NUM_BR-1 is written, the set is launched (launch pulse, acc_met_in and norm_in captured) and the FSM moves to FULL.
  - FULL: bm_valid without bm_first is ignored. bm_valid&bm_first returns to COLLECT and writes index 0.
- Boundary: bm_first arriving in COLLECT with cnt!=0 pulses frag_err, drops the partial set and restarts at index 0. A new launch may occur every NUM_BR cycles; the pipeline is fully pipelined.
- Stage A (launch+1): sum_k = sat(sext(bm_i_k) + acc_k - (norm_in ? NUM_VAL_SUB : 0)), where NUM_VAL_SUB=NORM_VAL. Arithmetic is at ACS_BITS+1, then saturated to [-2^(ACS_BITS-1), 2^(ACS_BITS-1)-1].
- Compare tree: $clog2(NUM_BR) registered levels.
  - Each node keeps {metric, index, i, q} of the larger input.
  - On a tie the lower index wins.
- Latency: out_valid asserts exactly 1+$clog2(NUM_BR) cycles after the launch cycle (3 for NUM_BR=4). Outputs hold between strobes.
- norm_req is registered with out_valid. It is 1 when acc_met_out[ACS_BITS-1:ACS_BITS-2]==2'b01 and the symbol was not normalised; otherwise 0. It holds until the next out_valid.

Optional Feature:
ACS_DECAY_EN:
- With the macro defined:
  - Adds port decay_factor in 8 (unsigned Q0.8).
  - acc_met_out = (survivor*decay_factor + 128) >> 8, signed with round-half-up, computed in one extra register stage. Latency becomes 2+$clog2(NUM_BR).
  - norm_req is evaluated on the decayed value.
- Without the macro: no port, no multiplier, latency as above.

Decomposition:
- Shared package acs_pkg:
  - function sat_add(a, b, width)
  - function clog2-based SEL_W helper
  - struct acs_node_t {metric, index, i, q}
  - localparam DECAY_ROUND=128
- One natural sub-module, acs_cmp_node: a registered 2-input max with tie-to-lower-index. It is instantiated NUM_BR-1 times via generate.

Test Plan:
- NUM_BR=4; bm_i=3,-2,7,7; acc_met_in all 0 -> out_valid 3 cycles after launch; sel_out=2 (tie, lower index); acc_met_out=7; i_out=7.
- Saturation: ACS_BITS=12, acc_0=2040, bm_i_0=20, others acc=-100 -> acc_met_out=2047, sel_out=0; norm_req=1.
- norm_in=1 with acc_1=1500, bm_i_1=10, others smaller -> acc_met_out=1500+10-1024=486; norm_req=0.
- bm_first after only 2 valid branches -> frag_err pulse for one cycle; no out_valid for the dropped set; the next full set decodes normally.
- Back-to-back symbols (bm_valid continuous, NUM_BR=8) -> one out_valid every 8 cycles, latency 4; results are per-symbol correct against the reference model.
- ACS_DECAY_EN, decay_factor=192, survivor=1000 -> acc_met_out=750 at latency 4 (NUM_BR=4); reset asserted mid-pipeline -> no out_valid, outputs 0.

Source files
------------

// File: rtl/acs_pkg.sv
// Shared types and helpers for the multi-branch add-compare-select unit.
// Compare-tree nodes carry fields at fixed maximum widths; the top slices them down.
package acs_pkg;

  localparam int DECAY_ROUND = 128;
  localparam int MET_BITS    = 32;
  localparam int IDX_BITS    = 3;
  localparam int RMAX_BITS   = 16;

  typedef struct packed {
    logic signed [MET_BITS-1:0]  metric;
    logic [IDX_BITS-1:0]         index;
    logic signed [RMAX_BITS-1:0] i;
    logic signed [RMAX_BITS-1:0] q;
  } acs_node_t;

  function automatic int sel_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Add at full precision, then clamp to a signed range of the given width.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = 33'(a) + 33'(b);
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -hi - 33'sd1;
    if (sum > hi) return 32'(hi);
    if (sum < lo) return 32'(lo);
    return 32'(sum);
  endfunction

endpackage

// File: rtl/acs_multi_branch_if.sv
// Branch-metric input and survivor output bundle of the multi-branch ACS.
// master drives the branch stream; slave is the ACS itself.
interface acs_multi_branch_if
  import acs_pkg::*;
#(
  parameter int NUM_BR   = 4,
  parameter int ACS_BITS = 12,
  parameter int ROT_BITS = 8
);
  localparam int SEL_W = sel_width(NUM_BR);

  logic                       bm_valid;
  logic                       bm_first;
  logic [ROT_BITS-1:0]        bm_i;
  logic [ROT_BITS-1:0]        bm_q;
  logic [NUM_BR*ACS_BITS-1:0] acc_met_in;
  logic                       norm_in;
  logic                       out_valid;
  logic [SEL_W-1:0]           sel_out;
  logic [ACS_BITS-1:0]        acc_met_out;
  logic [ROT_BITS-1:0]        i_out;
  logic [ROT_BITS-1:0]        q_out;
  logic                       norm_req;
  logic                       frag_err;

  modport master (
    output bm_valid, bm_first, bm_i, bm_q, acc_met_in, norm_in,
    input  out_valid, sel_out, acc_met_out, i_out, q_out, norm_req, frag_err
  );

  modport slave (
    input  bm_valid, bm_first, bm_i, bm_q, acc_met_in, norm_in,
    output out_valid, sel_out, acc_met_out, i_out, q_out, norm_req, frag_err
  );

endinterface

// File: rtl/acs_cmp_node.sv
// Registered two-input max for the ACS compare tree; ties go to the lower index.
module acs_cmp_node
  import acs_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      in_valid,
  input  acs_node_t a,
  input  acs_node_t b,
  output logic      out_valid,
  output acs_node_t y
);

  logic take_b;

  assign take_b = ($signed(b.metric) > $signed(a.metric)) ||
                  (($signed(b.metric) == $signed(a.metric)) && (b.index < a.index));

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) y <= take_b ? b : a;
    end
  end

endmodule

// File: rtl/acs_multi_branch.sv
// Multi-branch add-compare-select: serial branch collection, saturating add, pipelined max tree.
// Optional ACS_DECAY_EN adds a decay_factor port and a rounding decay stage on the survivor.
module acs_multi_branch
  import acs_pkg::*;
#(
  parameter int NUM_BR   = 4,
  parameter int ACS_BITS = 12,
  parameter int ROT_BITS = 8,
  parameter int NORM_VAL = 2 ** (ACS_BITS - 2)
) (
  input logic clk,
  input logic reset,
`ifdef ACS_DECAY_EN
  input logic [7:0] decay_factor,
`endif
  acs_multi_branch_if.slave bus
);

  localparam int SEL_W  = sel_width(NUM_BR);
  localparam int LEVELS = $clog2(NUM_BR);
  localparam int NODES  = 2 * NUM_BR - 1;
  localparam logic signed [31:0] NUM_VAL_SUB = 32'(NORM_VAL);

  // state   | meaning
  // COLLECT | gathering branches 0..NUM_BR-1 of a symbol
  // FULL    | set launched; waiting for the next bm_first
  typedef enum logic {COLLECT, FULL} state_t;

  state_t              state;
  logic [SEL_W-1:0]    cnt;
  logic [SEL_W-1:0]    wr_idx;
  logic                launch_now;
  logic [ROT_BITS-1:0] br_i [NUM_BR];
  logic [ROT_BITS-1:0] br_q [NUM_BR];
  acs_node_t           leaf_d [NUM_BR];
  acs_node_t           leaf [NUM_BR];
  logic [NUM_BR-1:0]   leaf_vld;
  acs_node_t           node_y [NUM_BR-1];
  logic                node_vld [NUM_BR-1];
  acs_node_t           all_node [NODES];
  logic                all_vld [NODES];
  logic                norm_at [LEVELS+1];
  logic [ACS_BITS-1:0] out_met;
  logic                out_norm;

  assign wr_idx     = bus.bm_first ? '0 : cnt;
  assign launch_now = bus.bm_valid && !bus.bm_first && (state == COLLECT) &&
                      (cnt == SEL_W'(NUM_BR - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= COLLECT;
      cnt          <= '0;
      bus.frag_err <= 1'b0;
      br_i         <= '{default: '0};
      br_q         <= '{default: '0};
    end else begin
      bus.frag_err <= 1'b0;
      if (bus.bm_valid && (bus.bm_first || state == COLLECT)) begin
        br_i[wr_idx] <= bus.bm_i;
        br_q[wr_idx] <= bus.bm_q;
      end
      if (bus.bm_valid) begin
        if (bus.bm_first) begin
          if (state == COLLECT && cnt != '0) bus.frag_err <= 1'b1;
          state <= COLLECT;
          cnt   <= SEL_W'(1);
        end else if (state == COLLECT) begin
          if (launch_now) begin
            state <= FULL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end

  // The last branch bypasses its register so the adders see it in the launch cycle.
  for (genvar k = 0; k < NUM_BR; k++) begin : g_leaf
    logic [ROT_BITS-1:0] bi;
    logic [ROT_BITS-1:0] bq;
    logic signed [31:0]  part;
    assign bi   = (k == NUM_BR - 1) ? bus.bm_i : br_i[k];
    assign bq   = (k == NUM_BR - 1) ? bus.bm_q : br_q[k];
    assign part = 32'($signed(bi)) - (bus.norm_in ? NUM_VAL_SUB : 32'sd0);
    assign leaf_d[k] = '{metric: sat_add(part, 32'($signed(bus.acc_met_in[k*ACS_BITS +: ACS_BITS])), ACS_BITS),
                         index:  IDX_BITS'(k),
                         i:      RMAX_BITS'($signed(bi)),
                         q:      RMAX_BITS'($signed(bq))};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      leaf_vld <= '0;
      leaf     <= '{default: '0};
    end else begin
      leaf_vld <= {NUM_BR{launch_now}};
      if (launch_now) leaf <= leaf_d;
    end
  end

  // Heap layout: node n has children 2n+1 and 2n+2; leaves sit at NUM_BR-1 onward.
  for (genvar n = 0; n < NODES; n++) begin : g_map
    if (n < NUM_BR - 1) begin : g_int
      assign all_node[n] = node_y[n];
      assign all_vld[n]  = node_vld[n];
    end else begin : g_lf
      assign all_node[n] = leaf[n-(NUM_BR-1)];
      assign all_vld[n]  = leaf_vld[n-(NUM_BR-1)];
    end
  end

  for (genvar n = 0; n < NUM_BR - 1; n++) begin : g_node
    acs_cmp_node u_node (
      .clk      (clk),
      .reset    (reset),
      .in_valid (all_vld[2*n+1]),
      .a        (all_node[2*n+1]),
      .b        (all_node[2*n+2]),
      .out_valid(node_vld[n]),
      .y        (node_y[n])
    );
  end

  // norm_in travels alongside the tree, one slot per depth (root is depth 0).
  always_ff @(posedge clk) begin
    if (reset) begin
      norm_at <= '{default: 1'b0};
    end else begin
      if (launch_now) norm_at[LEVELS] <= bus.norm_in;
      for (int d = 0; d < LEVELS; d++) begin
        if (all_vld[(1 << (d + 1)) - 1]) norm_at[d] <= norm_at[d+1];
      end
    end
  end

`ifdef ACS_DECAY_EN
  logic signed [ACS_BITS+8:0] prod;
  logic                       dec_valid;
  logic                       dec_norm;
  logic [ACS_BITS-1:0]        dec_met;
  acs_node_t                  dec_node;

  assign prod = $signed(node_y[0].metric[ACS_BITS-1:0]) * $signed({1'b0, decay_factor}) +
                (ACS_BITS + 9)'(DECAY_ROUND);

  always_ff @(posedge clk) begin
    if (reset) begin
      dec_valid <= 1'b0;
      dec_norm  <= 1'b0;
      dec_met   <= '0;
      dec_node  <= '0;
    end else begin
      dec_valid <= node_vld[0];
      if (node_vld[0]) begin
        dec_met  <= prod[ACS_BITS+7:8];
        dec_node <= node_y[0];
        dec_norm <= norm_at[0];
      end
    end
  end

  assign bus.out_valid = dec_valid;
  assign bus.sel_out   = dec_node.index[SEL_W-1:0];
  assign bus.i_out     = dec_node.i[ROT_BITS-1:0];
  assign bus.q_out     = dec_node.q[ROT_BITS-1:0];
  assign out_met       = dec_met;
  assign out_norm      = dec_norm;
`else
  assign bus.out_valid = node_vld[0];
  assign bus.sel_out   = node_y[0].index[SEL_W-1:0];
  assign bus.i_out     = node_y[0].i[ROT_BITS-1:0];
  assign bus.q_out     = node_y[0].q[ROT_BITS-1:0];
  assign out_met       = node_y[0].metric[ACS_BITS-1:0];
  assign out_norm      = norm_at[0];
`endif

  assign bus.acc_met_out = out_met;
  assign bus.norm_req    = !out_norm && (out_met[ACS_BITS-1:ACS_BITS-2] == 2'b01);

endmodule
